// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : viterbi_pkg
// Brief   : Shared state encoding and pipe-depth default for the BER monitor.
// Revision: 1.0 - initial release
// ============================================================================
package viterbi_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } ber_state_t;

  // Matches the reference-bit delay pipe depth so its reset zeros are flushed.
  localparam int unsigned SKIP_DEFAULT = 32;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Width-parameterised saturating accumulator (+1 on inc or add-bit).
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_inc,
  input  logic         i_add_bit,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_add;

  // Callers drive at most one of inc/add-bit, so the step is never above one.
  assign w_add = i_inc | i_add_bit;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (w_add && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ber_monitor.sv
`default_nettype none
// ============================================================================
// Module  : ber_monitor
// Brief   : Decoded-vs-reference bit error counter with windowed lock detect.
// Revision: 1.0 - initial release
// ============================================================================
module ber_monitor
  import viterbi_pkg::*;
#(
  parameter int SKIP         = SKIP_DEFAULT,
  parameter int WINDOW       = 1024,
  parameter int WIN_W        = 11,
  parameter int TOT_W        = 32,
  parameter int LOCK_THRESH  = 8,
  parameter int LOSS_WINDOWS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             ref_bit,
  input  logic             dec_bit,
  input  logic             clear,
  output logic             err_pulse,
  output logic             window_done,
  output logic [WIN_W-1:0] win_errs,
  output logic [TOT_W-1:0] total_errs,
  output logic [TOT_W-1:0] total_bits,
  output logic             locked
);

  localparam int SK_W  = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int BAD_W = $clog2(LOSS_WINDOWS + 1);
  localparam ber_state_t RST_STATE = (SKIP == 0) ? ACQ : WARMUP;
  localparam logic [SK_W-1:0]  SKIP_LAST = SK_W'(SKIP - 1);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW);
  localparam logic [WIN_W-1:0] THRESH    = WIN_W'(LOCK_THRESH);
  localparam logic [BAD_W-1:0] BAD_LAST  = BAD_W'(LOSS_WINDOWS - 1);

  ber_state_t       r_state;
  logic [SK_W-1:0]  r_skip;
  logic [BAD_W-1:0] r_bad;
  logic [WIN_W-1:0] r_wbits;
  logic [WIN_W-1:0] r_werrs;
  logic [WIN_W-1:0] r_win_errs;
  logic             r_err_pulse;
  logic             r_done;
  logic             r_locked;

  logic             w_err;
  logic             w_cmp;
  logic [WIN_W-1:0] w_wbits_nxt;
  logic [WIN_W-1:0] w_werrs_nxt;
  logic             w_close;
  logic             w_good;

  assign w_err       = ref_bit ^ dec_bit;
  assign w_cmp       = valid && !clear && (r_state != WARMUP);
  assign w_wbits_nxt = r_wbits + 1'b1;
  assign w_werrs_nxt = r_werrs + {{(WIN_W-1){1'b0}}, w_err};
  assign w_close     = w_cmp && (w_wbits_nxt == WIN_LAST);
  assign w_good      = (w_werrs_nxt <= THRESH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RST_STATE;
      r_skip      <= '0;
      r_bad       <= '0;
      r_wbits     <= '0;
      r_werrs     <= '0;
      r_win_errs  <= '0;
      r_err_pulse <= 1'b0;
      r_done      <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_err_pulse <= w_cmp && w_err;
      r_done      <= w_close;
      if (clear) begin
        // Only the open window and the totals are wiped; lock status survives.
        r_wbits <= '0;
        r_werrs <= '0;
      end else if (valid) begin
        case (r_state)
          WARMUP: begin
            r_skip <= r_skip + 1'b1;
            if (r_skip == SKIP_LAST) begin
              r_state <= ACQ;
            end
          end
          ACQ, LOCKED: begin
            if (w_close) begin
              r_wbits    <= '0;
              r_werrs    <= '0;
              r_win_errs <= w_werrs_nxt;
              if (r_state == ACQ) begin
                if (w_good) begin
                  r_state  <= LOCKED;
                  r_locked <= 1'b1;
                  r_bad    <= '0;
                end
              end else if (w_good) begin
                r_bad <= '0;
              end else if (r_bad == BAD_LAST) begin
                r_state  <= ACQ;
                r_locked <= 1'b0;
                r_bad    <= '0;
              end else begin
                r_bad <= r_bad + 1'b1;
              end
            end else begin
              r_wbits <= w_wbits_nxt;
              r_werrs <= w_werrs_nxt;
            end
          end
          default: r_state <= RST_STATE;
        endcase
      end
    end
  end

  sat_counter #(.W(TOT_W)) u_total_bits (
    .clk       (clk),
    .rst       (reset),
    .i_clear   (clear),
    .i_inc     (w_cmp),
    .i_add_bit (1'b0),
    .o_count   (total_bits)
  );

  sat_counter #(.W(TOT_W)) u_total_errs (
    .clk       (clk),
    .rst       (reset),
    .i_clear   (clear),
    .i_inc     (1'b0),
    .i_add_bit (w_cmp && w_err),
    .o_count   (total_errs)
  );

  assign err_pulse   = r_err_pulse;
  assign window_done = r_done;
  assign win_errs    = r_win_errs;
  assign locked      = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_ber_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_ber_monitor
// Brief   : Directed table, corner sequences and random traffic vs a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ber_monitor;

  localparam int SKIP         = 4;
  localparam int WINDOW       = 16;
  localparam int WIN_W        = 5;
  localparam int LOCK_THRESH  = 1;
  localparam int LOSS_WINDOWS = 2;
  localparam longint MAX32    = 64'd4294967295;
  localparam longint MAX4     = 64'd15;

  logic clk = 1'b0;
  logic reset = 1'b1, valid = 1'b0, ref_bit = 1'b0, dec_bit = 1'b0, clear = 1'b0;

  logic             err_pulse, window_done, locked;
  logic [WIN_W-1:0] win_errs;
  logic [31:0]      total_errs, total_bits;
  logic             s_err_pulse, s_window_done, s_locked;
  logic [WIN_W-1:0] s_win_errs;
  logic [3:0]       s_total_errs, s_total_bits;

  always #5 clk = ~clk;

  ber_monitor #(.SKIP(SKIP), .WINDOW(WINDOW), .WIN_W(WIN_W), .TOT_W(32),
                .LOCK_THRESH(LOCK_THRESH), .LOSS_WINDOWS(LOSS_WINDOWS)) dut (
    .clk(clk), .reset(reset), .valid(valid), .ref_bit(ref_bit), .dec_bit(dec_bit),
    .clear(clear), .err_pulse(err_pulse), .window_done(window_done),
    .win_errs(win_errs), .total_errs(total_errs), .total_bits(total_bits),
    .locked(locked));

  // Narrow-total build sharing the same stimulus, used to observe saturation.
  ber_monitor #(.SKIP(SKIP), .WINDOW(WINDOW), .WIN_W(WIN_W), .TOT_W(4),
                .LOCK_THRESH(LOCK_THRESH), .LOSS_WINDOWS(LOSS_WINDOWS)) dut_sat (
    .clk(clk), .reset(reset), .valid(valid), .ref_bit(ref_bit), .dec_bit(dec_bit),
    .clear(clear), .err_pulse(s_err_pulse), .window_done(s_window_done),
    .win_errs(s_win_errs), .total_errs(s_total_errs), .total_bits(s_total_bits),
    .locked(s_locked));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int     m_seen;
  bit     m_warm;
  bit     m_locked;
  int     m_bad, m_wbits, m_werrs, e_win;
  longint m_tb, m_te;
  bit     e_err, e_done;

  function automatic longint sat(longint x, longint mx);
    return (x > mx) ? mx : x;
  endfunction

  function automatic void model(bit rs, bit v, bit r, bit d, bit c);
    bit e;
    e_err  = 1'b0;
    e_done = 1'b0;
    if (rs) begin
      m_seen = 0; m_warm = 1'b1; m_locked = 1'b0; m_bad = 0;
      m_wbits = 0; m_werrs = 0; e_win = 0; m_tb = 0; m_te = 0;
    end else if (c) begin
      m_tb = 0; m_te = 0; m_wbits = 0; m_werrs = 0;
    end else if (v) begin
      if (m_warm) begin
        m_seen++;
        if (m_seen == SKIP) m_warm = 1'b0;
      end else begin
        e = r ^ d;
        e_err = e;
        m_tb++; m_te += e;
        m_wbits++; m_werrs += e;
        if (m_wbits == WINDOW) begin
          e_done = 1'b1;
          e_win  = m_werrs;
          if (!m_locked) begin
            if (m_werrs <= LOCK_THRESH) begin m_locked = 1'b1; m_bad = 0; end
          end else if (m_werrs <= LOCK_THRESH) begin
            m_bad = 0;
          end else begin
            m_bad++;
            if (m_bad == LOSS_WINDOWS) begin m_locked = 1'b0; m_bad = 0; end
          end
          m_wbits = 0; m_werrs = 0;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit rs, input bit v, input bit r, input bit d, input bit c);
    reset = rs; valid = v; ref_bit = r; dec_bit = d; clear = c;
    @(posedge clk);
    model(rs, v, r, d, c);
    #1;
    chk("err_pulse",   64'(err_pulse),    64'(e_err));
    chk("window_done", 64'(window_done),  64'(e_done));
    chk("win_errs",    64'(win_errs),     64'(e_win));
    chk("locked",      64'(locked),       64'(m_locked));
    chk("total_bits",  64'(total_bits),   64'(sat(m_tb, MAX32)));
    chk("total_errs",  64'(total_errs),   64'(sat(m_te, MAX32)));
    chk("sat_bits",    64'(s_total_bits), 64'(sat(m_tb, MAX4)));
    chk("sat_errs",    64'(s_total_errs), 64'(sat(m_te, MAX4)));
  endtask

  task automatic run_window(input int nerr);
    for (int b = 1; b <= WINDOW; b++) step(1'b0, 1'b1, 1'b0, (b <= nerr), 1'b0);
  endtask

  typedef struct {
    bit rs, v, r, d, c;
    bit x_err, x_done, x_lock;
    int x_win, x_tb, x_te;
  } vec_t;

  vec_t tbl[21];

  initial begin
    // Reset, four warm-up mismatches, then one window with a single error at bit 7.
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 1; i <= 4; i++) tbl[i] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int b = 1; b <= 16; b++)
      tbl[4+b] = '{0, 1, 0, (b == 7), 0, (b == 7), (b == 16), (b == 16),
                   (b == 16) ? 1 : 0, b, (b >= 7) ? 1 : 0};

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rs, tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d_err",  i), 64'(err_pulse),   64'(tbl[i].x_err));
      chk($sformatf("tbl%0d_done", i), 64'(window_done), 64'(tbl[i].x_done));
      chk($sformatf("tbl%0d_lock", i), 64'(locked),      64'(tbl[i].x_lock));
      chk($sformatf("tbl%0d_win",  i), 64'(win_errs),    64'(tbl[i].x_win));
      chk($sformatf("tbl%0d_tb",   i), 64'(total_bits),  64'(tbl[i].x_tb));
      chk($sformatf("tbl%0d_te",   i), 64'(total_errs),  64'(tbl[i].x_te));
    end

    // Loss of lock needs two consecutive bad windows; a good one in between resets it.
    run_window(2); chk("lock_w1", 64'(locked), 64'd1); chk("done_w1", 64'(window_done), 64'd1);
    run_window(0); chk("lock_w2", 64'(locked), 64'd1);
    run_window(3); chk("lock_w3", 64'(locked), 64'd1);
    run_window(3); chk("lock_w4", 64'(locked), 64'd0); chk("done_w4", 64'(window_done), 64'd1);

    // Clear with a valid mismatch mid-window: bit discarded, window restarts.
    run_window(0); chk("relock", 64'(locked), 64'd1);
    for (int b = 1; b <= 8; b++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_tb", 64'(total_bits), 64'd0);
    chk("clr_te", 64'(total_errs), 64'd0);
    chk("clr_err", 64'(err_pulse), 64'd0);
    chk("clr_lock", 64'(locked), 64'd1);
    for (int b = 1; b <= 15; b++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_nodone", 64'(window_done), 64'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_done", 64'(window_done), 64'd1);

    // Reset wins over simultaneous clear and valid; warm-up starts over.
    for (int b = 1; b <= 5; b++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_lock", 64'(locked), 64'd0);
    chk("rst_tb", 64'(total_bits), 64'd0);
    chk("rst_win", 64'(win_errs), 64'd0);
    for (int b = 1; b <= SKIP; b++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("warm_err", 64'(err_pulse), 64'd0);
      chk("warm_tb", 64'(total_bits), 64'd0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_warm_err", 64'(err_pulse), 64'd1);
    chk("post_warm_tb", 64'(total_bits), 64'd1);

    // Saturation of the 4-bit totals.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int b = 1; b <= SKIP; b++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int b = 1; b <= 20; b++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat4_errs", 64'(s_total_errs), 64'd15);
    chk("sat4_bits", 64'(s_total_bits), 64'd15);
    chk("wide_errs", 64'(total_errs), 64'd20);
    chk("wide_bits", 64'(total_bits), 64'd20);

    // Random traffic in segments of differing error density.
    for (int seg = 0; seg < 12; seg++) begin
      int pe;
      pe = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 4 : 20);
      for (int k = 0; k < 60; k++) begin
        bit v, e, r, c, rs;
        v  = ($urandom_range(0, 99) < 75);
        e  = ($urandom_range(0, 99) < pe);
        r  = 1'($urandom);
        c  = ($urandom_range(0, 99) < 2);
        rs = ($urandom_range(0, 199) == 0);
        step(rs, v, r, r ^ e, c);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ber_monitor.md
Name: ber_monitor

Overview:
- Sits directly downstream of the decoder's 32-stage reference-bit delay pipe and the traceback output.
- Compares each decoded bit against the delayed original bit and counts errors per fixed window and cumulatively.
- Runs a lock-detect state machine that declares the decoder synchronised or lost.
- Drives the bit-error-rate status seen by the host and the test harness.

Parameters:
- SKIP, 32, number of initial valid bits ignored after reset (matches delay-pipe depth, flushes pipe zeros).
- WINDOW, 1024, valid bits per measurement window (>= 2).
- WIN_W, 11, width of window error/bit counters (must hold WINDOW).
- TOT_W, 32, width of cumulative counters.
- LOCK_THRESH, 8, max errors in a window still counted as a good window.
- LOSS_WINDOWS, 3, consecutive bad windows in LOCKED that force loss of lock (>= 1).

Ports:
- clk, input, 1, system clock, all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- valid, input, 1, strobe: ref_bit and dec_bit are valid this cycle.
- ref_bit, input, 1, original bit from delay pipe output.
- dec_bit, input, 1, decoded bit from traceback.
- clear, input, 1, synchronous clear of cumulative and current-window counters.
- err_pulse, output, 1, registered 1-cycle flag: last compared bit mismatched.
- window_done, output, 1, 1-cycle pulse when a window closes.
- win_errs, output, WIN_W, error count of last completed window (held until next window_done).
- total_errs, output, TOT_W, cumulative errors, saturating.
- total_bits, output, TOT_W, cumulative compared bits, saturating.
- locked, output, 1, high in LOCKED state.

Behaviour:
- Interface: one clock `clk`. Reset `reset` is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: every output 0. All internal counters 0. State WARMUP.
- States: WARMUP, ACQ, LOCKED.
- WARMUP:
  - Count valid cycles. No comparison is made and no counters other than the skip counter change.
  - On the SKIP-th valid, move to ACQ. That bit itself is not compared.
  - SKIP=0 means reset goes straight to ACQ.
- ACQ/LOCKED, on each valid:
  - Compare: err = ref_bit XOR dec_bit.
  - err_pulse = err on the next cycle; it is 0 in any cycle after a non-valid cycle.
  - Window bit counter increments. The window error counter adds err.
  - total_bits increments and total_errs adds err; both saturate at all-ones with no wrap.
- Window close, on the valid that makes the window bit count equal WINDOW (error count includes that bit):
  - Next cycle: window_done=1, and win_errs updates.
  - Window counters restart at 0, so the following valid is bit 1 of the new window. There is no dead cycle.
  - A good window has errors <= LOCK_THRESH.
  - ACQ: good window -> LOCKED with bad_cnt=0; bad window -> stay in ACQ.
  - LOCKED: good window -> bad_cnt=0. Bad window -> bad_cnt+1; if it reaches LOSS_WINDOWS -> ACQ with bad_cnt=0.
  - locked changes in the same cycle window_done pulses.
- clear, outside reset:
  - Zeros total_errs, total_bits and the current window counters. A valid bit in the same cycle is discarded.
  - State, bad_cnt, win_errs, locked and the WARMUP skip count are unchanged.
  - Any window close or comparison that would have happened that cycle is suppressed.
- Non-valid cycles: no state or counter change. window_done and err_pulse are 0.
- Back-to-back valids every cycle are supported at full rate.

Decomposition:
- Shared package `viterbi_pkg`: state encoding constants (WARMUP=2'd0, ACQ=2'd1, LOCKED=2'd2) and the default SKIP=32, tied to the delay-pipe depth.
- One natural sub-module, `sat_counter`: width-parameterised saturating accumulator with inc, add-bit and clear inputs. It is instantiated for total_bits and total_errs.
- The FSM and window logic stay in ber_monitor.

Test Plan (bench params SKIP=4, WINDOW=16, WIN_W=5, LOCK_THRESH=1, LOSS_WINDOWS=2):
1. Reset then 4 valids with ref≠dec -> no err_pulse, total_bits=0, state ACQ after the 4th valid.
2. After warmup, 16 valids with 1 mismatch at bit 7 -> err_pulse one cycle after bit 7. window_done one cycle after bit 16 with win_errs=1, locked=1, total_errs=1, total_bits=16.
3. From LOCKED: window with 2 errors, then window with 0 errors, then two windows with 3 errors -> locked stays 1 after the first two windows and drops to 0 at the 4th window_done.
4. clear asserted together with valid mid-window (bit 9, mismatch) -> total_bits=0, total_errs=0, no err_pulse, locked unchanged. The next window closes 16 valids after the clear.
5. Reset asserted mid-window with clear and valid also high -> all outputs 0 next cycle, state WARMUP, 4 more valids needed before comparisons resume.
6. Force total_errs near saturation (TOT_W=4 build, 20 mismatches) -> total_errs holds at 15 with no wrap, total_bits holds at 15.
